// File: rtl/pkt_buf_writer_if.sv
// RX beat stream and FIFO write port of the packet buffer ingress stage.
// The master is the stream source and FIFO model. The slave is pkt_buf_writer.
interface pkt_buf_writer_if;
    logic [63:0] in_data;
    logic        in_sop;
    logic        in_eop;
    logic [2:0]  in_empty;
    logic        in_err;
    logic        in_val;
    logic [79:0] wdata;
    logic        wval;
    logic [11:0] fifo_usedw;
    logic        fifo_full;

    modport master (
        output in_data, in_sop, in_eop, in_empty, in_err, in_val,
        output fifo_usedw, fifo_full,
        input  wdata, wval
    );

    modport slave (
        input  in_data, in_sop, in_eop, in_empty, in_err, in_val,
        input  fifo_usedw, fifo_full,
        output wdata, wval
    );
endinterface

// File: rtl/pkt_buf_writer.sv
// Packs a non-stallable 64-bit RX stream into 80-bit FIFO words. It admits whole
// packets by worst-case space and ensures that every packet reaching the FIFO is framed.
module pkt_buf_writer #(
    parameter int DEPTH     = 2048,
    parameter int MAX_WORDS = 190,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             xrst,
    pkt_buf_writer_if.slave  bus,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam int BW = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, PASS = 2'd1, DROP = 2'd2} state_t;

    state_t        state_r, state_raw_s, state_n_s;
    logic [BW-1:0] cnt_r, cnt_n_s;
    logic [79:0]   wdata_r;
    logic          wval_r;
    logic          wr_raw_s, pkt_raw_s, drop_raw_s;
    logic          wr_s, blk_s, pkt_inc_s, drop_inc_s;
    logic          sop_s, eop_s, err_s;
    logic [2:0]    empty_s;
    logic [12:0]   need_s;
    logic          adm_ok_s;

    // The +1 reserves the word that is still in flight in the output register
    assign need_s   = {1'b0, bus.fifo_usedw} + 13'(MAX_WORDS) + 13'd1;
    assign adm_ok_s = (need_s <= 13'(DEPTH));

    // Next-state and write decode for one input beat
    always_comb begin
        state_raw_s = state_r;
        cnt_n_s     = cnt_r;
        wr_raw_s    = 1'b0;
        pkt_raw_s   = 1'b0;
        drop_raw_s  = 1'b0;
        sop_s       = 1'b0;
        eop_s       = 1'b0;
        err_s       = 1'b0;
        empty_s     = 3'd0;
        if (bus.in_val) begin
            case (state_r)
                IDLE, DROP: begin
                    if (bus.in_sop) begin
                        if (adm_ok_s) begin
                            wr_raw_s = 1'b1;
                            sop_s    = 1'b1;
                            cnt_n_s  = BW'(1);
                            if (bus.in_eop) begin
                                eop_s       = 1'b1;
                                empty_s     = bus.in_empty;
                                err_s       = bus.in_err;
                                pkt_raw_s   = 1'b1;
                                state_raw_s = IDLE;
                            end else begin
                                state_raw_s = PASS;
                            end
                        end else begin
                            drop_raw_s  = 1'b1;
                            state_raw_s = bus.in_eop ? IDLE : DROP;
                        end
                    end else if (bus.in_eop) begin
                        state_raw_s = IDLE;
                    end else begin
                        state_raw_s = state_r;
                    end
                end
                PASS: begin
                    wr_raw_s = 1'b1;
                    if (bus.in_sop) begin
                        // A new SOP closes the unterminated packet and drops the new one
                        eop_s       = 1'b1;
                        err_s       = 1'b1;
                        pkt_raw_s   = 1'b1;
                        drop_raw_s  = 1'b1;
                        state_raw_s = bus.in_eop ? IDLE : DROP;
                    end else if (bus.in_eop) begin
                        eop_s       = 1'b1;
                        empty_s     = bus.in_empty;
                        err_s       = bus.in_err;
                        pkt_raw_s   = 1'b1;
                        state_raw_s = IDLE;
                    end else if (cnt_r + BW'(1) == BW'(MAX_WORDS)) begin
                        eop_s       = 1'b1;
                        err_s       = 1'b1;
                        pkt_raw_s   = 1'b1;
                        state_raw_s = DROP;
                    end else begin
                        cnt_n_s = cnt_r + BW'(1);
                    end
                end
                default: begin
                    state_raw_s = IDLE;
                end
            endcase
        end else begin
            state_raw_s = state_r;
        end
    end

    // A full FIFO suppresses the write and aborts the rest of the packet
    assign blk_s      = wr_raw_s & bus.fifo_full;
    assign wr_s       = wr_raw_s & ~bus.fifo_full;
    assign pkt_inc_s  = pkt_raw_s & ~blk_s;
    assign drop_inc_s = drop_raw_s | blk_s;
    assign state_n_s  = blk_s ? (bus.in_eop ? IDLE : DROP) : state_raw_s;

    // State, output word and saturating statistics registers
    always_ff @(posedge clk) begin
        if (!xrst) begin
            state_r  <= IDLE;
            cnt_r    <= BW'(0);
            wdata_r  <= 80'd0;
            wval_r   <= 1'b0;
            pkt_cnt  <= CNT_W'(0);
            drop_cnt <= CNT_W'(0);
        end else begin
            state_r <= state_n_s;
            cnt_r   <= cnt_n_s;
            wval_r  <= wr_s;
            if (wr_s) begin
                wdata_r <= {sop_s, eop_s, empty_s, err_s, 10'd0, bus.in_data};
            end
            if (pkt_inc_s && (pkt_cnt != {CNT_W{1'b1}})) begin
                pkt_cnt <= pkt_cnt + CNT_W'(1);
            end
            if (drop_inc_s && (drop_cnt != {CNT_W{1'b1}})) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.wdata = wdata_r;
    assign bus.wval  = wval_r;
endmodule
